// File: rtl/console_pkg.sv
// Shared types and constants for the text console: geometry defaults, ASCII codes, FSM states.
// No logic of its own; CONSOLE_CURSOR_EN adds the CURSOR state.
package console_pkg;

    localparam int CONSOLE_COLS = 50;
    localparam int CONSOLE_ROWS = 30;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_SCREEN
`ifdef CONSOLE_CURSOR_EN
        ,
        CURSOR
`endif
    } console_state_t;

    // Everything from space upward except DEL lands on screen as a glyph.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_SPACE) && (b != ASCII_DEL);
    endfunction

endpackage

// File: rtl/video_console_if.sv
// Console bundle: CPU byte stream (valid/ready), clear pulse, status, and the video memory write port.
// Pure wiring; the slave modport is the console, the master modport is the CPU/display side.
interface video_console_if;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        clear_req;
    logic        busy;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        video_write_enable;
    logic [7:0]  video_write_data;
    logic [10:0] video_write_addr;

    modport master (
        output char_valid, char_data, clear_req,
        input  char_ready, busy, cursor_col, cursor_row,
        input  video_write_enable, video_write_data, video_write_addr
    );

    modport slave (
        input  char_valid, char_data, clear_req,
        output char_ready, busy, cursor_col, cursor_row,
        output video_write_enable, video_write_data, video_write_addr
    );
endinterface

// File: rtl/console_fill.sv
// Sweeps count_i consecutive addresses from start_addr_i, one fill write per cycle while run_i is high.
// Combinational outputs off a counter; done_o marks the last write; dropping run_i rewinds the counter.
module console_fill #(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic [10:0] start_addr_i,
    input  logic [10:0] count_i,
    output logic        we_o,
    output logic [7:0]  data_o,
    output logic [10:0] addr_o,
    output logic        done_o
);
    logic [10:0] cnt_q, cnt_d;

    assign we_o   = run_i;
    assign data_o = FILL_CHAR;
    assign addr_o = start_addr_i + cnt_q;
    assign done_o = run_i && (cnt_q == count_i - 11'd1);

    always_comb begin
        cnt_d = cnt_q + 11'd1;
        if (!run_i || done_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/video_console.sv
// Text console: consumes CPU bytes, tracks the cursor, emits registered video-memory writes (accept N -> write N+1).
// char_ready is low while any clear runs or is pending; CONSOLE_CURSOR_EN adds a drawn cursor glyph.
module video_console
    import console_pkg::*;
#(
    parameter int         COLS      = CONSOLE_COLS,
    parameter int         ROWS      = CONSOLE_ROWS,
    parameter logic [7:0] FILL_CHAR = ASCII_SPACE
`ifdef CONSOLE_CURSOR_EN
    ,
    parameter logic [7:0] CURSOR_GLYPH = 8'hFF
`endif
) (
    input  logic           CLK_CPU,
    input  logic           reset,
    video_console_if.slave bus
);
`ifdef CONSOLE_CURSOR_EN
    localparam console_state_t CLEAR_EXIT = CURSOR;
`else
    localparam console_state_t CLEAR_EXIT = IDLE;
`endif

    console_state_t state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [10:0] row_base_q, row_base_d;
    logic        clear_pending_q, clear_pending_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [10:0] waddr_q, waddr_d;

    logic        accept, last_row;
    logic [10:0] cur_addr, base_adv;
    logic [4:0]  row_adv;
    logic        fill_run, fill_we, fill_done;
    logic [7:0]  fill_data;
    logic [10:0] fill_addr, fill_start, fill_count;

    assign bus.char_ready         = (state_q == IDLE) && !clear_pending_q && !bus.clear_req;
    assign bus.busy               = (state_q != IDLE);
    assign bus.cursor_col         = col_q;
    assign bus.cursor_row         = row_q;
    assign bus.video_write_enable = we_q;
    assign bus.video_write_data   = wdata_q;
    assign bus.video_write_addr   = waddr_q;

    assign accept   = bus.char_valid && bus.char_ready;
    // Address tracked as running row base plus column, so no multiplier in the path.
    assign cur_addr = row_base_q + {5'd0, col_q};
    assign last_row = (row_q == 5'(ROWS - 1));
    assign row_adv  = last_row ? 5'd0 : row_q + 5'd1;
    assign base_adv = last_row ? 11'd0 : row_base_q + 11'(COLS);

    assign fill_run   = (state_q == CLR_LINE) || (state_q == CLR_SCREEN);
    assign fill_start = (state_q == CLR_SCREEN) ? 11'd0 : row_base_q;
    assign fill_count = (state_q == CLR_SCREEN) ? 11'(COLS * ROWS) : 11'(COLS);

    console_fill #(.FILL_CHAR(FILL_CHAR)) u_fill (
        .clk_i        (CLK_CPU),
        .rst_i        (reset),
        .run_i        (fill_run),
        .start_addr_i (fill_start),
        .count_i      (fill_count),
        .we_o         (fill_we),
        .data_o       (fill_data),
        .addr_o       (fill_addr),
        .done_o       (fill_done)
    );

    always_comb begin
        state_d         = state_q;
        col_d           = col_q;
        row_d           = row_q;
        row_base_d      = row_base_q;
        clear_pending_d = clear_pending_q | bus.clear_req;
        we_d            = 1'b0;
        wdata_d         = FILL_CHAR;
        waddr_d         = cur_addr;
        case (state_q)
            IDLE: begin
                if (clear_pending_q) begin
                    state_d         = CLR_SCREEN;
                    clear_pending_d = bus.clear_req;
                    col_d           = '0;
                    row_d           = '0;
                    row_base_d      = '0;
                end else if (accept) begin
                    if (is_printable(bus.char_data)) begin
                        we_d    = 1'b1;
                        wdata_d = bus.char_data;
                        if (col_q == 6'(COLS - 1)) begin
                            col_d      = '0;
                            row_d      = row_adv;
                            row_base_d = base_adv;
                            state_d    = CLR_LINE;
                        end else begin
                            col_d = col_q + 6'd1;
`ifdef CONSOLE_CURSOR_EN
                            state_d = CURSOR;
`endif
                        end
                    end else begin
                        case (bus.char_data)
                            ASCII_LF: begin
`ifdef CONSOLE_CURSOR_EN
                                we_d = 1'b1;
`endif
                                col_d      = '0;
                                row_d      = row_adv;
                                row_base_d = base_adv;
                                state_d    = CLR_LINE;
                            end
                            ASCII_CR: begin
`ifdef CONSOLE_CURSOR_EN
                                we_d    = 1'b1;
                                state_d = CURSOR;
`endif
                                col_d = '0;
                            end
                            ASCII_BS: begin
                                if (col_q != 6'd0) begin
                                    col_d = col_q - 6'd1;
`ifdef CONSOLE_CURSOR_EN
                                    // Old cell erased here; the glyph redraw covers the new cell.
                                    we_d    = 1'b1;
                                    state_d = CURSOR;
`else
                                    we_d    = 1'b1;
                                    waddr_d = cur_addr - 11'd1;
`endif
                                end
                            end
                            ASCII_FF: clear_pending_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            CLR_LINE, CLR_SCREEN: begin
                we_d    = fill_we;
                wdata_d = fill_data;
                waddr_d = fill_addr;
                if (fill_done) begin
                    state_d = CLEAR_EXIT;
                end
            end
`ifdef CONSOLE_CURSOR_EN
            CURSOR: begin
                we_d    = 1'b1;
                wdata_d = CURSOR_GLYPH;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_CPU) begin
        if (reset) begin
            state_q         <= CLR_SCREEN;
            col_q           <= '0;
            row_q           <= '0;
            row_base_q      <= '0;
            clear_pending_q <= 1'b0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            waddr_q         <= '0;
        end else begin
            state_q         <= state_d;
            col_q           <= col_d;
            row_q           <= row_d;
            row_base_q      <= row_base_d;
            clear_pending_q <= clear_pending_d;
            we_q            <= we_d;
            wdata_q         <= wdata_d;
            waddr_q         <= waddr_d;
        end
    end
endmodule

// File: tb/tb_video_console.sv
// Directed bench for video_console: logs every video write and checks it against hand-derived expectations.
module tb_video_console;
    import console_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    video_console_if bus();

    video_console dut (
        .CLK_CPU (clk),
        .reset   (reset),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [10:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          wc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        if (bus.video_write_enable === 1'b1) begin
            wa_q.push_back(bus.video_write_addr);
            wd_q.push_back(bus.video_write_data);
            wc_q.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        bus.char_data  = b;
        bus.char_valid = 1'b1;
        while (bus.char_ready !== 1'b1 && t < 4000) begin
            tick();
            t++;
        end
        if (bus.char_ready !== 1'b1) chk("send_timeout", bus.char_ready, 1);
        tick();
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (bus.char_ready !== 1'b1 && t < 4000) begin
            tick();
            t++;
        end
        if (bus.char_ready !== 1'b1) chk(tag, bus.char_ready, 1);
    endtask

    // Expect exactly n fill writes at base..base+n-1 on consecutive cycles.
    task automatic check_fill(input string tag, input int base, input int n);
        int bad = 0;
        int m;
        chk({tag, "_count"}, wa_q.size(), n);
        m = (wa_q.size() < n) ? wa_q.size() : n;
        for (int i = 0; i < m; i++) begin
            if (wa_q[i] !== 11'(base + i) || wd_q[i] !== 8'h20 || wc_q[i] !== wc_q[0] + i) bad++;
        end
        chk({tag, "_bad_entries"}, bad, 0);
    endtask

    initial begin
        logic [7:0] ch;
        int bad;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        bus.clear_req  = 1'b0;

        // Reset and the power-up screen clear.
        tick(); tick(); tick();
        chk("rst_we", bus.video_write_enable, 0);
        chk("rst_col", bus.cursor_col, 0);
        chk("rst_row", bus.cursor_row, 0);
        chk("rst_busy", bus.busy, 1);
        chk("rst_ready", bus.char_ready, 0);
        clear_log();
        reset = 1'b0;
        wait_idle("boot_timeout");
        check_fill("boot", 0, 1500);
        chk("boot_busy", bus.busy, 0);
        chk("boot_ready", bus.char_ready, 1);

        // Two printables back to back.
        clear_log();
        send(8'h41);
        send(8'h42);
        tick(); tick();
        chk("ab_count", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            chk("a_addr", wa_q[0], 0);
            chk("a_data", wd_q[0], 8'h41);
            chk("b_addr", wa_q[1], 1);
            chk("b_data", wd_q[1], 8'h42);
            chk("ab_gap", wc_q[1] - wc_q[0], 1);
        end
        chk("ab_col", bus.cursor_col, 2);
        chk("ab_row", bus.cursor_row, 0);

        // CR homes the column without writing.
        clear_log();
        send(ASCII_CR);
        tick();
        chk("cr_writes", wa_q.size(), 0);
        chk("cr_col", bus.cursor_col, 0);

        // Fill row 0 exactly: wraps to row 1 and clears it.
        clear_log();
        for (int i = 0; i < 50; i++) begin
            send(8'h61 + 8'(i % 26));
        end
        chk("wrap_busy", bus.busy, 1);
        chk("wrap_text_count", wa_q.size(), 50);
        bad = 0;
        for (int i = 0; i < 50 && i < wa_q.size(); i++) begin
            ch = 8'h61 + 8'(i % 26);
            if (wa_q[i] !== 11'(i) || wd_q[i] !== ch) bad++;
        end
        chk("wrap_text_bad", bad, 0);
        for (int i = 0; i < 50 && wa_q.size() > 0; i++) begin
            void'(wa_q.pop_front());
            void'(wd_q.pop_front());
            void'(wc_q.pop_front());
        end
        wait_idle("line1_timeout");
        check_fill("line1", 50, 50);
        chk("wrap_col", bus.cursor_col, 0);
        chk("wrap_row", bus.cursor_row, 1);

        // Walk to the last row, then LF wraps to row 0 and clears it.
        for (int i = 0; i < 28; i++) begin
            send(ASCII_LF);
            wait_idle("lf_timeout");
        end
        chk("row29", bus.cursor_row, 29);
        clear_log();
        send(ASCII_LF);
        wait_idle("lfwrap_timeout");
        check_fill("lfwrap", 0, 50);
        chk("lfwrap_row", bus.cursor_row, 0);
        chk("lfwrap_col", bus.cursor_col, 0);

        // Backspace at column 3 of row 2, then at column 0.
        send(ASCII_LF); wait_idle("lf2_timeout");
        send(ASCII_LF); wait_idle("lf3_timeout");
        send(8'h78); send(8'h79); send(8'h7A);
        tick();
        chk("pre_bs_col", bus.cursor_col, 3);
        chk("pre_bs_row", bus.cursor_row, 2);
        clear_log();
        send(ASCII_BS);
        tick(); tick();
        chk("bs_count", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            chk("bs_addr", wa_q[0], 102);
            chk("bs_data", wd_q[0], 8'h20);
        end
        chk("bs_col", bus.cursor_col, 2);
        send(ASCII_CR);
        clear_log();
        send(ASCII_BS);
        tick(); tick();
        chk("bs0_writes", wa_q.size(), 0);
        chk("bs0_col", bus.cursor_col, 0);
        chk("bs0_row", bus.cursor_row, 2);

        // clear_req beats a simultaneous character.
        clear_log();
        bus.char_data  = 8'h51;
        bus.char_valid = 1'b1;
        bus.clear_req  = 1'b1;
        #1;
        chk("clr_ready", bus.char_ready, 0);
        tick();
        bus.clear_req  = 1'b0;
        bus.char_valid = 1'b0;
        wait_idle("clr_timeout");
        check_fill("clr", 0, 1500);
        chk("clr_col", bus.cursor_col, 0);
        chk("clr_row", bus.cursor_row, 0);

        // Form feed behaves as a clear request.
        send(8'h4D);
        tick();
        chk("m_col", bus.cursor_col, 1);
        clear_log();
        send(ASCII_FF);
        wait_idle("ff_timeout");
        check_fill("ff", 0, 1500);
        chk("ff_col", bus.cursor_col, 0);
        chk("ff_row", bus.cursor_row, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
